lfsr_decode: RTL and testbench



---
 rtl/lfsr_decode.sv | 102 ++++++++++
 tb/tb_lfsr_decode.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lfsr_decode.sv
// lfsr_decode: inverse of the Fibonacci LFSR counter. Accepts an LFSR state
// word and returns its index, the number of steps from SEED needed to reach
// it. An internal copy of the LFSR is stepped once per clock until it
// matches the latched target or every sequence position has been tried.
//
// Ports:
//   clock    in   rising-edge clock
//   i_reset  in   asynchronous, active-high reset
//   i_valid  in   request valid
//   o_ready  out  block can accept a request (IDLE)
//   i_state  in   LFSR state word to decode
//   o_valid  out  result valid (DONE)
//   i_ready  in   downstream accepts result
//   o_count  out  decoded index (all ones when not found)
//   o_found  out  1 = i_state lies on the sequence
//   o_busy   out  search in progress
module lfsr_decode #(
   parameter int unsigned POLY = 16'b1101_0000_0000_1000,
   parameter logic [$clog2(POLY)-1:0] SEED = '1
) (
   input  logic                    clock,
   input  logic                    i_reset,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [$clog2(POLY)-1:0] i_state,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [$clog2(POLY)-1:0] o_count,
   output logic                    o_found,
   output logic                    o_busy
);

   localparam int SIZE = $clog2(POLY);
   localparam logic [SIZE-1:0] TAPS = POLY[SIZE-1:0];
   // Highest index a maximal sequence can hold; reaching it unmatched means
   // the target is not on the sequence (e.g. all zeros).
   localparam logic [SIZE-1:0] LAST_CNT = {{(SIZE-1){1'b1}}, 1'b0};

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSearch = 2'd1;
   localparam logic [1:0] StDone   = 2'd2;

   logic [1:0]      state;
   logic [SIZE-1:0] sreg;
   logic [SIZE-1:0] sreg_next;
   logic [SIZE-1:0] cnt;
   logic [SIZE-1:0] target;

   always_comb begin
      sreg_next = {sreg[SIZE-2:0], ^(sreg & TAPS)};
   end

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         state   <= StIdle;
         sreg    <= SEED;
         cnt     <= '0;
         target  <= '0;
         o_count <= '0;
         o_found <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (i_valid) begin
                  target <= i_state;
                  sreg   <= SEED;
                  cnt    <= '0;
                  state  <= StSearch;
               end
            end
            StSearch: begin
               if (sreg == target) begin
                  o_count <= cnt;
                  o_found <= 1'b1;
                  state   <= StDone;
               end else if (cnt == LAST_CNT) begin
                  o_count <= '1;
                  o_found <= 1'b0;
                  state   <= StDone;
               end else begin
                  sreg <= sreg_next;
                  cnt  <= cnt + 1'b1;
               end
            end
            StDone: begin
               // Result registers stay untouched here, so they hold while stalled.
               if (i_ready) begin
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   always_comb begin
      o_ready = (state == StIdle);
      o_busy  = (state == StSearch);
      o_valid = (state == StDone);
   end

endmodule

// File: tb/tb_lfsr_decode.sv
// Directed testbench for lfsr_decode: known sequence positions, model-derived
// states at chosen indices, the all-zero state, result stall and mid-search
// reset.
module tb_lfsr_decode;

   logic        clock;
   logic        i_reset;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_state;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_count;
   logic        o_found;
   logic        o_busy;

   int total = 0;
   int bad   = 0;

   lfsr_decode dut (
      .clock   (clock),
      .i_reset (i_reset),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_state (i_state),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_count (o_count),
      .o_found (o_found),
      .o_busy  (o_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference LFSR: state after n steps from the all-ones seed.
   function automatic logic [15:0] lfsr_at(input int n);
      logic [15:0] s;
      s = 16'hFFFF;
      for (int i = 0; i < n; i++) s = {s[14:0], ^(s & 16'hD008)};
      return s;
   endfunction

   // Issue one request, measure edges from accept to o_valid, check the
   // result, optionally stall in DONE, then consume it.
   task automatic decode(input string tag, input logic [15:0] st, input logic [15:0] exp_cnt,
                         input logic exp_found, input int exp_lat, input int stall);
      int lat;
      @(negedge clock);
      i_state = st;
      i_valid = 1'b1;
      @(posedge clock);
      #1;
      i_valid = 1'b0;
      i_state = 16'($urandom);
      chk({tag, ".ready_after_accept"}, o_ready, 1'b0);
      lat = 0;
      while (!o_valid && lat < 70000) begin
         @(posedge clock);
         #1;
         lat++;
      end
      chk({tag, ".latency"}, lat, exp_lat);
      chk({tag, ".count"}, o_count, exp_cnt);
      chk({tag, ".found"}, o_found, exp_found);
      for (int i = 0; i < stall; i++) begin
         @(negedge clock);
         i_valid = (i % 2 == 0);
         i_state = 16'hFFFF;
         @(posedge clock);
         #1;
         chk({tag, ".stall_valid"}, o_valid, 1'b1);
         chk({tag, ".stall_count"}, o_count, exp_cnt);
         chk({tag, ".stall_found"}, o_found, exp_found);
         chk({tag, ".stall_ready"}, o_ready, 1'b0);
      end
      @(negedge clock);
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge clock);
      #1;
      i_ready = 1'b0;
      chk({tag, ".valid_dropped"}, o_valid, 1'b0);
      chk({tag, ".ready_back"}, o_ready, 1'b1);
   endtask

   initial begin
      int n;
      i_reset = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_state = 16'h0000;
      #12;
      chk("rst.ready", o_ready, 1'b1);
      chk("rst.valid", o_valid, 1'b0);
      chk("rst.busy", o_busy, 1'b0);
      chk("rst.count", o_count, 16'h0000);
      chk("rst.found", o_found, 1'b0);
      @(negedge clock);
      i_reset = 1'b0;

      // Index k produces o_valid after k+1 edges following the accept edge.
      decode("seed", 16'hFFFF, 16'd0, 1'b1, 1, 0);
      decode("k1", 16'hFFFE, 16'd1, 1'b1, 2, 0);
      decode("k2", 16'hFFFC, 16'd2, 1'b1, 3, 0);
      decode("k3", 16'hFFF8, 16'd3, 1'b1, 4, 0);
      decode("k4", 16'hFFF0, 16'd4, 1'b1, 5, 0);
      decode("k5", 16'hFFE1, 16'd5, 1'b1, 6, 0);

      decode("n1000", lfsr_at(1000), 16'd1000, 1'b1, 1001, 0);
      for (int r = 0; r < 10; r++) begin
         n = $urandom_range(6, 1500);
         decode("nrand", lfsr_at(n), 16'(n), 1'b1, n + 1, 0);
      end

      decode("stall", 16'hFFF8, 16'd3, 1'b1, 4, 5);

      // Reset during a search for index 500.
      @(negedge clock);
      i_state = lfsr_at(500);
      i_valid = 1'b1;
      @(posedge clock);
      #1;
      i_valid = 1'b0;
      repeat (100) @(posedge clock);
      #2;
      chk("midrst.busy_before", o_busy, 1'b1);
      i_reset = 1'b1;
      #1;
      chk("midrst.busy", o_busy, 1'b0);
      chk("midrst.ready", o_ready, 1'b1);
      chk("midrst.valid", o_valid, 1'b0);
      @(negedge clock);
      i_reset = 1'b0;
      decode("after_rst", 16'hFFF8, 16'd3, 1'b1, 4, 0);

      // All-zero state is never reached: full search then not-found.
      decode("zero", 16'h0000, 16'hFFFF, 1'b0, 65535, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
